// File: rtl/hamming_decoder_serial_pkg.sv
// Shared sizes and code-layout helper for the bit-serial Hamming(21,16) decoder.
package hamming_decoder_serial_pkg;

  localparam int CODE_W    = 21;
  localparam int DATA_W    = 16;
  localparam int SYN_W     = 5;
  localparam int FRAME_LEN = 22;

  localparam logic [SYN_W-1:0] LAST_POS = 5'd21;

  // Code position (1-based) holding data bit idx; parity occupies powers of two.
  function automatic int data_pos(input int idx);
    int n;
    int result;
    n      = 0;
    result = 0;
    for (int pos = 1; pos <= CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (n == idx) begin
          result = pos;
        end
        n++;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/hamming_decoder_serial_correct_extract.sv
// Combinational single-bit correction followed by data-bit extraction.
module hamming_correct_extract
  import hamming_decoder_serial_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic [SYN_W-1:0]  syn_i,
  output logic [DATA_W-1:0] data_o
);

  logic [CODE_W-1:0] flip_s;
  logic [CODE_W-1:0] fixed_s;

  // Syndromes 22..31 match no position, so the mask stays empty and nothing flips.
  always_comb begin
    flip_s  = {CODE_W{1'b0}};
    fixed_s = code_i;
    data_o  = {DATA_W{1'b0}};
    for (int k = 0; k < CODE_W; k++) begin
      flip_s[k] = (syn_i == SYN_W'(k + 1));
    end
    fixed_s = code_i ^ flip_s;
    for (int i = 0; i < DATA_W; i++) begin
      data_o[i] = fixed_s[data_pos(i) - 1];
    end
  end

endmodule

// File: rtl/hamming_decoder_serial.sv
// Bit-serial Hamming(21,16) decoder: samples a codeword every 22 clocks and
// accumulates its syndrome one position per clock before correcting.
module hamming_decoder_serial
  import hamming_decoder_serial_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] e,
  output logic [DATA_W-1:0] op,
  output logic [SYN_W-1:0]  p
);

  logic [SYN_W-1:0]  cnt_q,  cnt_d;
  logic [CODE_W-1:0] ereg_q, ereg_d;
  logic [SYN_W-1:0]  acc_q,  acc_d;
  logic [DATA_W-1:0] op_q,   op_d;
  logic [SYN_W-1:0]  p_q,    p_d;

  logic [31:0]       ereg_ext_s;
  logic [SYN_W-1:0]  idx_s;
  logic              bit_s;
  logic [SYN_W-1:0]  syn_s;
  logic [DATA_W-1:0] fixed_s;

  // Syndrome including the current position, so the final edge sees the full value.
  always_comb begin
    ereg_ext_s = {11'd0, ereg_q};
    idx_s      = cnt_q - 5'd1;
    if (cnt_q != 5'd0) begin
      bit_s = ereg_ext_s[idx_s];
    end else begin
      bit_s = 1'b0;
    end
    syn_s = acc_q ^ (bit_s ? cnt_q : 5'd0);
  end

  hamming_correct_extract u_correct (
    .code_i (ereg_q),
    .syn_i  (syn_s),
    .data_o (fixed_s)
  );

  // Frame sequencing: sample, accumulate 21 positions, then publish.
  always_comb begin
    cnt_d  = cnt_q;
    ereg_d = ereg_q;
    acc_d  = acc_q;
    op_d   = op_q;
    p_d    = p_q;
    case (cnt_q)
      5'd0: begin
        ereg_d = e;
        acc_d  = 5'd0;
        cnt_d  = 5'd1;
      end
      LAST_POS: begin
        acc_d = syn_s;
        p_d   = syn_s;
        op_d  = fixed_s;
        cnt_d = 5'd0;
      end
      default: begin
        if (cnt_q < LAST_POS) begin
          acc_d = syn_s;
          cnt_d = cnt_q + 5'd1;
        end else begin
          cnt_d = 5'd0;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 5'd0;
      ereg_q <= 21'd0;
      acc_q  <= 5'd0;
      op_q   <= 16'd0;
      p_q    <= 5'd0;
    end else begin
      cnt_q  <= cnt_d;
      ereg_q <= ereg_d;
      acc_q  <= acc_d;
      op_q   <= op_d;
      p_q    <= p_d;
    end
  end

  assign op = op_q;
  assign p  = p_q;

endmodule

// File: tb/tb_hamming_decoder_serial.sv
// Scoreboard bench for hamming_decoder_serial: directed vectors, random frames,
// output hold/latency and mid-frame reset.
module tb_hamming_decoder_serial;

  logic        clk;
  logic        rst;
  logic [20:0] e;
  logic [15:0] op;
  logic [4:0]  p;

  int n_checks;
  int n_fails;

  logic [15:0] q_op[$];
  logic [4:0]  q_p[$];
  logic [15:0] prev_op;
  logic [4:0]  prev_p;

  localparam logic [20:0] CLEAN = 21'b010100111100001101100;

  hamming_decoder_serial dut (
    .clk (clk),
    .rst (rst),
    .e   (e),
    .op  (op),
    .p   (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_syn(input logic [20:0] w);
    logic [4:0] s;
    s = 5'd0;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 21; k++) begin
        if ((((k + 1) >> j) & 1) == 1) s[j] = s[j] ^ w[k];
      end
    end
    return s;
  endfunction

  function automatic logic [15:0] model_data(input logic [20:0] w);
    int dpos[16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};
    logic [4:0]  s;
    logic [20:0] c;
    logic [15:0] d;
    s = model_syn(w);
    c = w;
    if (s >= 5'd1 && s <= 5'd21) c[s - 5'd1] = ~c[s - 5'd1];
    for (int i = 0; i < 16; i++) d[i] = c[dpos[i] - 1];
    return d;
  endfunction

  // Called just before a sampling edge; returns 1 ns after the frame's 22nd edge.
  task automatic run_frame(input string tag, input logic [20:0] ev,
                           input logic [15:0] exp_op, input logic [4:0] exp_p,
                           input bit scramble);
    logic [15:0] got_op_exp;
    logic [4:0]  got_p_exp;
    q_op.push_back(exp_op);
    q_p.push_back(exp_p);
    e = ev;
    @(posedge clk);
    #1;
    if (scramble) e = 21'($urandom);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_hold_op"}, {16'd0, op}, {16'd0, prev_op});
    check({tag, "_hold_p"}, {27'd0, p}, {27'd0, prev_p});
    @(posedge clk);
    #1;
    got_op_exp = q_op.pop_front();
    got_p_exp  = q_p.pop_front();
    check({tag, "_op"}, {16'd0, op}, {16'd0, got_op_exp});
    check({tag, "_p"}, {27'd0, p}, {27'd0, got_p_exp});
    prev_op = got_op_exp;
    prev_p  = got_p_exp;
  endtask

  initial begin
    logic [20:0] rv;
    n_checks = 0;
    n_fails  = 0;
    prev_op  = 16'd0;
    prev_p   = 5'd0;
    rst = 1'b1;
    e   = 21'd0;
    repeat (2) @(negedge clk);
    check("reset_op", {16'd0, op}, 32'd0);
    check("reset_p", {27'd0, p}, 32'd0);
    rst = 1'b0;

    run_frame("clean", CLEAN, 16'h578D, 5'd0, 1'b0);
    run_frame("data_pos7", CLEAN & ~(21'd1 << 6), 16'h578D, 5'd7, 1'b1);
    run_frame("par_pos16", CLEAN | (21'd1 << 15), 16'h578D, 5'd16, 1'b0);
    run_frame("dbl_3_5", CLEAN ^ ((21'd1 << 2) | (21'd1 << 4)), 16'h578A, 5'd6, 1'b1);
    run_frame("dbl_11_20", CLEAN ^ ((21'd1 << 10) | (21'd1 << 19)), 16'h17CD, 5'd31, 1'b0);
    run_frame("pos21", CLEAN ^ (21'd1 << 20), 16'h578D, 5'd21, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rv = 21'($urandom);
      run_frame("rand", rv, model_data(rv), model_syn(rv), 1'b1);
    end

    // Mid-frame reset at cnt=10 after a frame that left nonzero outputs.
    run_frame("pre_rst", CLEAN ^ (21'd1 << 8), 16'h578D, 5'd9, 1'b0);
    e = CLEAN ^ (21'd1 << 12);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_op", {16'd0, op}, 32'd0);
    check("midrst_p", {27'd0, p}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_op = 16'd0;
    prev_p  = 5'd0;
    run_frame("post_rst", CLEAN ^ (21'd1 << 12), 16'h578D, 5'd13, 1'b1);
    run_frame("post_rst2", CLEAN, 16'h578D, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
